// File: rtl/vpu_pkg.sv
// Shared constants and state encoding for the VPU load/store address sequencer.
package vpu_pkg;

  localparam logic [6:0] OPC_VLOAD  = 7'b0000111;
  localparam logic [6:0] OPC_VSTORE = 7'b0100111;

  localparam int VLMAX_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GEN  = 2'd1,
    ST_FIN  = 2'd2
  } state_t;

endpackage

// File: rtl/vpu_imm_ext.sv
// I-type / S-type 12-bit immediate extraction with sign extension to 32 bits.
module vpu_imm_ext (
  input  logic [31:0] instr,
  input  logic        imm_sel,
  output logic [31:0] imm
);

  logic [11:0] imm12;
  logic        unused_fields;

  // Bits [19:12] (rs1/funct3) carry no immediate information in either format.
  assign unused_fields = ^instr[19:12];

  assign imm12 = imm_sel ? {instr[31:25], instr[11:7]} : instr[31:20];
  assign imm   = {{20{imm12[11]}}, imm12};

endmodule

// File: rtl/vec_mem_addr_seq.sv
// Vector load/store address sequencer: one strided element address per handshake.
//   state   | meaning
//   ST_IDLE | ready for a new instruction
//   ST_GEN  | presenting element addresses
//   ST_FIN  | one-cycle completion pulse
module vec_mem_addr_seq
  import vpu_pkg::*;
#(
  parameter int VLMAX  = VLMAX_DEF,
  parameter int ADDR_W = 32,
  parameter int CNT_W  = $clog2(VLMAX + 1)
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              Instr_Valid,
  output logic              Instr_Ready,
  input  logic [31:0]       Instruction_Code,
  input  logic [ADDR_W-1:0] Base_Addr,
  input  logic [ADDR_W-1:0] Stride,
  input  logic [CNT_W-1:0]  Vl,
  output logic              Addr_Valid,
  input  logic              Addr_Ready,
  output logic [ADDR_W-1:0] Addr,
  output logic [CNT_W-1:0]  Elem_Idx,
  output logic              Is_Store,
  output logic              Last,
  output logic              Busy,
  output logic              Done,
  output logic              Illegal
);

  state_t            state, state_nxt;
  logic [6:0]        opcode;
  logic              imm_sel, legal, accept, handshake, last;
  logic [31:0]       imm32;
  logic [ADDR_W-1:0] ext_imm, add_a, add_b, sum;
  logic [ADDR_W-1:0] addr_q, stride_q;
  logic [CNT_W-1:0]  count_q, idx_q, vl_clamp;
  logic              is_store_q, illegal_q;

  assign opcode  = Instruction_Code[6:0];
  assign imm_sel = (opcode == OPC_VSTORE);
  assign legal   = (opcode == OPC_VLOAD) || imm_sel;

  vpu_imm_ext u_imm_ext (
    .instr   (Instruction_Code),
    .imm_sel (imm_sel),
    .imm     (imm32)
  );

  if (ADDR_W > 32) begin : g_imm_wide
    assign ext_imm = {{(ADDR_W-32){imm32[31]}}, imm32};
  end else begin : g_imm_narrow
    assign ext_imm = imm32[ADDR_W-1:0];
  end

  assign vl_clamp  = (Vl > CNT_W'(VLMAX)) ? CNT_W'(VLMAX) : Vl;
  assign accept    = Instr_Valid && (state == ST_IDLE);
  assign handshake = (state == ST_GEN) && Addr_Ready;
  assign last      = (state == ST_GEN) && (idx_q == count_q - CNT_W'(1));

  // Single adder: start address in IDLE, stride accumulate in GEN.
  assign add_a = (state == ST_IDLE) ? Base_Addr : addr_q;
  assign add_b = (state == ST_IDLE) ? ext_imm   : stride_q;
  assign sum   = add_a + add_b;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept && legal) state_nxt = (vl_clamp == '0) ? ST_FIN : ST_GEN;
      ST_GEN:  if (handshake && last) state_nxt = ST_FIN;
      ST_FIN:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      addr_q     <= '0;
      stride_q   <= '0;
      count_q    <= '0;
      idx_q      <= '0;
      is_store_q <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      illegal_q <= accept && !legal;
      if (accept && legal) begin
        addr_q     <= sum;
        stride_q   <= Stride;
        count_q    <= vl_clamp;
        idx_q      <= '0;
        is_store_q <= imm_sel;
      end else if (handshake && !last) begin
        addr_q <= sum;
        idx_q  <= idx_q + CNT_W'(1);
      end
    end
  end

  assign Instr_Ready = (state == ST_IDLE);
  assign Addr_Valid  = (state == ST_GEN);
  assign Busy        = (state != ST_IDLE);
  assign Done        = (state == ST_FIN);
  assign Last        = last;
  assign Illegal     = illegal_q;
  assign Addr        = addr_q;
  assign Elem_Idx    = idx_q;
  assign Is_Store    = is_store_q;

endmodule

// File: tb/tb_vec_mem_addr_seq.sv
// Self-checking bench for vec_mem_addr_seq: directed vector table, reset abort, random instructions.
module tb_vec_mem_addr_seq;

  localparam int VLMAX  = 8;
  localparam int ADDR_W = 32;
  localparam int CNT_W  = 4;

  logic              Clk = 1'b0;
  logic              Rst_n = 1'b0;
  logic              Instr_Valid = 1'b0;
  logic              Instr_Ready;
  logic [31:0]       Instruction_Code = '0;
  logic [ADDR_W-1:0] Base_Addr = '0;
  logic [ADDR_W-1:0] Stride = '0;
  logic [CNT_W-1:0]  Vl = '0;
  logic              Addr_Valid;
  logic              Addr_Ready = 1'b0;
  logic [ADDR_W-1:0] Addr;
  logic [CNT_W-1:0]  Elem_Idx;
  logic              Is_Store;
  logic              Last;
  logic              Busy;
  logic              Done;
  logic              Illegal;

  int checks = 0;
  int failures = 0;

  vec_mem_addr_seq #(.VLMAX(VLMAX), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .Clk              (Clk),
    .Rst_n            (Rst_n),
    .Instr_Valid      (Instr_Valid),
    .Instr_Ready      (Instr_Ready),
    .Instruction_Code (Instruction_Code),
    .Base_Addr        (Base_Addr),
    .Stride           (Stride),
    .Vl               (Vl),
    .Addr_Valid       (Addr_Valid),
    .Addr_Ready       (Addr_Ready),
    .Addr             (Addr),
    .Elem_Idx         (Elem_Idx),
    .Is_Store         (Is_Store),
    .Last             (Last),
    .Busy             (Busy),
    .Done             (Done),
    .Illegal          (Illegal)
  );

  always #5 Clk = ~Clk;

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [31:0] instr;
    logic [31:0] base;
    logic [31:0] stride;
    int          vl;
    int          stall0;
    int          exp_n;
    logic [31:0] exp_first;
    logic        exp_store;
    logic        exp_ill;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Reference: effective start = base + signed 12-bit immediate, plain integer arithmetic.
  function automatic logic [31:0] model_first(input logic [31:0] instr, input logic [31:0] base);
    int imm;
    if (instr[6:0] == 7'h27) imm = int'(instr[31:25]) * 32 + int'(instr[11:7]);
    else                     imm = int'(instr[31:20]);
    if (imm >= 2048) imm -= 4096;
    return base + 32'(imm);
  endfunction

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_instr_ready"}, 64'(Instr_Ready), 64'(1));
    chk({tag, "_addr_valid"},  64'(Addr_Valid),  64'(0));
    chk({tag, "_addr"},        64'(Addr),        64'(0));
    chk({tag, "_elem_idx"},    64'(Elem_Idx),    64'(0));
    chk({tag, "_is_store"},    64'(Is_Store),    64'(0));
    chk({tag, "_last"},        64'(Last),        64'(0));
    chk({tag, "_busy"},        64'(Busy),        64'(0));
    chk({tag, "_done"},        64'(Done),        64'(0));
    chk({tag, "_illegal"},     64'(Illegal),     64'(0));
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
  task automatic run(input vec_t v, input bit rnd_ready);
    int k = 0;
    int stalls = 0;
    int cyc = 0;
    bit fin = 1'b0;
    logic [31:0] exp_addr;
    chk("instr_ready_before_accept", 64'(Instr_Ready), 64'(1));
    Instr_Valid      = 1'b1;
    Instruction_Code = v.instr;
    Base_Addr        = v.base;
    Stride           = v.stride;
    Vl               = CNT_W'(v.vl);
    Addr_Ready       = 1'b1;
    @(posedge Clk);
    #1;
    Instr_Valid      = 1'b0;
    Instruction_Code = $urandom;
    Base_Addr        = $urandom;
    Stride           = $urandom;
    Vl               = CNT_W'($urandom_range(0, 15));
    if (v.exp_ill) begin
      @(negedge Clk);
      chk("illegal_pulse",       64'(Illegal),     64'(1));
      chk("illegal_no_done",     64'(Done),        64'(0));
      chk("illegal_no_valid",    64'(Addr_Valid),  64'(0));
      chk("illegal_instr_ready", 64'(Instr_Ready), 64'(1));
      @(negedge Clk);
      chk("illegal_one_cycle",   64'(Illegal),     64'(0));
      chk("illegal_no_done2",    64'(Done),        64'(0));
      return;
    end
    while (!fin) begin
      @(negedge Clk);
      cyc++;
      if (cyc > 200) begin
        checks++;
        failures++;
        $display("FAIL cycle_budget exceeded elements_seen=%0d required=%0d", k, v.exp_n);
        Instr_Valid = 1'b0;
        fin = 1'b1;
      end else if (k < v.exp_n) begin
        exp_addr = v.exp_first + v.stride * 32'(k);
        chk("addr_valid",  64'(Addr_Valid),  64'(1));
        chk("addr",        64'(Addr),        64'(exp_addr));
        chk("elem_idx",    64'(Elem_Idx),    64'(k));
        chk("last",        64'(Last),        64'(k == v.exp_n - 1));
        chk("is_store",    64'(Is_Store),    64'(v.exp_store));
        chk("busy",        64'(Busy),        64'(1));
        chk("instr_ready", 64'(Instr_Ready), 64'(0));
        chk("done_early",  64'(Done),        64'(0));
        if (k == 0 && stalls < v.stall0) begin
          Addr_Ready = 1'b0;
          stalls++;
        end else begin
          Addr_Ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        if (Addr_Ready) k++;
        Instr_Valid = 1'($urandom_range(0, 1));
      end else begin
        chk("done",          64'(Done),        64'(1));
        chk("done_no_valid", 64'(Addr_Valid),  64'(0));
        chk("done_busy",     64'(Busy),        64'(1));
        chk("done_ready",    64'(Instr_Ready), 64'(0));
        chk("done_illegal",  64'(Illegal),     64'(0));
        Instr_Valid = 1'b0;
        fin = 1'b1;
      end
    end
    @(negedge Clk);
    chk("done_one_cycle", 64'(Done),        64'(0));
    chk("idle_busy",      64'(Busy),        64'(0));
    chk("idle_ready",     64'(Instr_Ready), 64'(1));
    chk("idle_no_valid",  64'(Addr_Valid),  64'(0));
  endtask

  vec_t tbl[8];

  initial begin
    vec_t v;
    int   sel;
    logic [6:0] opc;

    tbl[0] = '{32'hFFC00007, 32'h00001000, 32'h00000004,  3, 0, 3, 32'h00000FFC, 1'b0, 1'b0};
    tbl[1] = '{32'h00000427, 32'h00002000, 32'hFFFFFFF8,  2, 3, 2, 32'h00002008, 1'b1, 1'b0};
    tbl[2] = '{32'h00000007, 32'h00000100, 32'h00000004, 12, 0, 8, 32'h00000100, 1'b0, 1'b0};
    tbl[3] = '{32'h00000007, 32'h00000500, 32'h00000004,  0, 0, 0, 32'h00000500, 1'b0, 1'b0};
    tbl[4] = '{32'h00000033, 32'h00000600, 32'h00000004,  3, 0, 0, 32'h00000000, 1'b0, 1'b1};
    tbl[5] = '{32'h00000007, 32'hFFFFFFF8, 32'h00000008,  2, 0, 2, 32'hFFFFFFF8, 1'b0, 1'b0};
    tbl[6] = '{32'hFE000FA7, 32'h00004000, 32'h00000100,  4, 1, 4, 32'h00003FFF, 1'b1, 1'b0};
    tbl[7] = '{32'h7FF00007, 32'h00000000, 32'h00000001,  1, 0, 1, 32'h000007FF, 1'b0, 1'b0};

    #12;
    chk_reset_vals("reset");
    @(negedge Clk);
    Rst_n = 1'b1;
    @(negedge Clk);

    for (int i = 0; i < 8; i++) run(tbl[i], 1'b0);

    // Reset in the middle of a 5-element load, after two addresses were accepted.
    Instr_Valid      = 1'b1;
    Instruction_Code = 32'h00000007;
    Base_Addr        = 32'h00003000;
    Stride           = 32'h00000010;
    Vl               = CNT_W'(5);
    Addr_Ready       = 1'b1;
    @(posedge Clk);
    #1;
    Instr_Valid = 1'b0;
    @(negedge Clk);
    @(negedge Clk);
    @(negedge Clk);
    chk("abort_third_addr", 64'(Addr),     64'(32'h00003020));
    chk("abort_third_idx",  64'(Elem_Idx), 64'(2));
    Rst_n = 1'b0;
    #1;
    chk_reset_vals("abort");
    @(negedge Clk);
    @(negedge Clk);
    Rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge Clk);
      chk("post_abort_no_valid", 64'(Addr_Valid),  64'(0));
      chk("post_abort_no_done",  64'(Done),        64'(0));
      chk("post_abort_ready",    64'(Instr_Ready), 64'(1));
    end
    run(tbl[0], 1'b0);

    // Random instructions against the reference model.
    for (int i = 0; i < 40; i++) begin
      sel = int'($urandom_range(0, 9));
      v.instr = $urandom;
      if (sel == 0) begin
        opc = 7'($urandom_range(0, 127));
        if (opc == 7'h07 || opc == 7'h27) opc = 7'h33;
      end else if (sel <= 5) begin
        opc = 7'h07;
      end else begin
        opc = 7'h27;
      end
      v.instr[6:0] = opc;
      v.base      = $urandom;
      v.stride    = $urandom;
      v.vl        = int'($urandom_range(0, 12));
      v.stall0    = int'($urandom_range(0, 2));
      v.exp_ill   = (sel == 0);
      v.exp_store = (opc == 7'h27);
      v.exp_n     = v.exp_ill ? 0 : ((v.vl > VLMAX) ? VLMAX : v.vl);
      v.exp_first = model_first(v.instr, v.base);
      run(v, 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vec_mem_addr_seq.md
# vec_mem_addr_seq

Vector memory address sequencer for the VPU load/store path. Accepts one vector load or store instruction with its scalar base address, stride and vector length. Forms the effective start address from the sign-extended I-type (load) or S-type (store) immediate. Emits one element address per cycle toward the memory interface under a valid/ready handshake, then pulses completion.

## Interface
Parameters:
- VLMAX, 8, maximum elements per instruction; larger Vl is clamped.
- ADDR_W, 32, address/operand width.
- CNT_W, $clog2(VLMAX+1), width of Vl and element index.

Ports:
- Clk  in  1  single clock, rising edge.
- Rst_n  in  1  asynchronous, active-low reset.
- Instr_Valid  in  1  instruction offered.
- Instr_Ready  out  1  instruction accepted when high with Instr_Valid.
- Instruction_Code  in  32  raw instruction word.
- Base_Addr  in  ADDR_W  scalar base (rs1 value).
- Stride  in  ADDR_W  byte stride, two's complement.
- Vl  in  CNT_W  element count.
- Addr_Valid  out  1  element address valid.
- Addr_Ready  in  1  memory side accepts address.
- Addr  out  ADDR_W  element address.
- Elem_Idx  out  CNT_W  index of current element.
- Is_Store  out  1  1 = store, 0 = load.
- Last  out  1  current element is the final one.
- Busy  out  1  instruction in progress.
- Done  out  1  one-cycle completion pulse.
- Illegal  out  1  one-cycle pulse for an unsupported opcode.

## Operation
- Opcode is Instruction_Code[6:0]. 7'b0000111 is a load (Imm_Sel=0, I-immediate [31:20]). 7'b0100111 is a store (Imm_Sel=1, S-immediate {[31:25],[11:7]}). Both immediates are sign-extended from bit 31.
- FSM states IDLE, GEN, FIN.
  - IDLE: Instr_Ready=1.
    - On accept with a legal opcode and clamped Vl>0: latch Is_Store, Addr <= Base_Addr + ext_imm, Stride, count = min(Vl,VLMAX), Elem_Idx <= 0; go to GEN.
    - Legal opcode with Vl==0: go to FIN, no addresses emitted.
    - Illegal opcode: pulse Illegal next cycle, stay IDLE, no Done.
  - GEN: Addr_Valid=1. On Addr_Valid&&Addr_Ready: if Last, go to FIN; else Addr <= Addr + Stride, Elem_Idx++.
  - FIN: Done=1 for exactly one cycle, then IDLE.
- Last = (Elem_Idx == count-1) while in GEN.
- Busy = state != IDLE.
- Arithmetic is modulo 2^ADDR_W. Wrap-around is silent, with no flag.
- Addr, Elem_Idx, Is_Store and Last are held stable while Addr_Valid && !Addr_Ready. Addr_Valid never drops without a handshake.
- Instr_Valid and operand changes outside IDLE are ignored. Operands are sampled only on the accept edge.

## Timing
- Reset values: state IDLE, so Instr_Ready=1. Addr_Valid=0, Addr=0, Elem_Idx=0, Is_Store=0, Last=0, Busy=0, Done=0, Illegal=0.
- Reset asserted mid-instruction aborts immediately. No Done, and no further addresses after release.
- Accept at edge N: first address is valid in cycle N+1.
- With Addr_Ready held high, one address per cycle. For an n-element instruction, addresses appear in cycles N+1..N+n, Done in N+n+1, and the next accept is possible at edge N+n+2.
- Vl==0: Done in cycle N+1.
- Illegal: Illegal in cycle N+1. A new accept is possible at that same edge.
- Done, Illegal and all outputs are registered. Instr_Ready and Last are decoded from registered state only, with no input-to-output combinational path.

## Structure
- Package vpu_pkg holds:
  - OPC_VLOAD and OPC_VSTORE constants;
  - the state encoding (IDLE/GEN/FIN);
  - the VLMAX default.
- Sub-module vpu_imm_ext: combinational 12-bit I/S immediate extraction plus 32-bit sign extension, selected by Imm_Sel. The sequencer instantiates it once on Instruction_Code.
- One FSM, one ADDR_W adder (start address and stride accumulate share the adder through a mux), one CNT_W counter.

## Test plan
- Load 0xFFC00007 (imm = -4), Base=0x1000, Stride=4, Vl=3, Addr_Ready=1 -> addresses 0x0FFC, 0x1000, 0x1004 in consecutive cycles. Last on the third. Done one cycle later. Is_Store=0.
- Store with S-immediate +8 (word 0x00000427), Base=0x2000, Stride=-8, Vl=2, Addr_Ready low for 3 cycles on element 0 -> 0x2008 held stable for 3 cycles, then 0x2000. Is_Store=1.
- Vl=12 with VLMAX=8 -> exactly 8 addresses, Elem_Idx 0..7, then Done.
- Vl=0 -> no Addr_Valid, Done in cycle N+1. Opcode 0x33 -> Illegal pulse, no Done, Instr_Ready remains 1.
- Base=0xFFFFFFF8, imm=0, Stride=8, Vl=2 -> 0xFFFFFFF8, then 0x00000000 (wrap).
- Rst_n asserted after the second of 5 addresses -> all outputs return to reset values immediately. After release, no stray Addr_Valid or Done, and a new instruction is accepted normally.
